// File: rtl/i2s_pkg.sv
// Shared types for the I2S/TDM transmitter and receiver: serial formats and
// transmitter control states.
package i2s_pkg;

    typedef enum logic [1:0] {
        FMT_I2S = 2'd0,
        FMT_LJ  = 2'd1,
        FMT_DSP = 2'd2
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_e;

    // Reserved encoding 3 behaves as I2S.
    function automatic fmt_e decode_fmt(input logic [1:0] f);
        case (f)
            2'd1:    return FMT_LJ;
            2'd2:    return FMT_DSP;
            default: return FMT_I2S;
        endcase
    endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO with occupancy level; head word is visible
// combinationally on dout_o whenever the FIFO is not empty.
module i2s_frame_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level == LW'(DEPTH));
    assign empty_o = (level == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem[rd_ptr];
    assign level_o = level;

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (!do_push && do_pop)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// Multi-channel I2S / left-justified / DSP-TDM serial transmitter with a
// frame FIFO; inserts silent frames on underrun so ws never stops in RUN.
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                         sclk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic [1:0]                   fmt_i,
    input  logic [CHANNELS*SAMPLE_W-1:0] frame_i,
    input  logic                         frame_valid_i,
    output logic                         frame_ready_o,
    output logic                         ws_o,
    output logic                         sdata_o,
    output logic                         busy_o,
    output logic                         underrun_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o
);

    localparam int unsigned FW = CHANNELS*SAMPLE_W;
    localparam int unsigned BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam int unsigned CW = $clog2(CHANNELS);
    localparam logic [BW-1:0]       BIT_LAST  = BW'(SLOT_W-1);
    localparam logic [CW-1:0]       SLOT_LAST = CW'(CHANNELS-1);
    localparam logic [CW-1:0]       SLOT_HALF = CW'(CHANNELS/2);
    localparam logic [SAMPLE_W-1:0] SMP_MSB   = {1'b1, {(SAMPLE_W-1){1'b0}}};

    tx_state_e         state, nstate;
    logic [BW-1:0]     bit_cnt, nbit;
    logic [CW-1:0]     slot_cnt, nslot;
    fmt_e              fmt_q, nfmt;
    logic [FW-1:0]     frame_q, nframe;
    logic [SAMPLE_W-1:0] smp;
    logic              lj_q, nlj;
    logic              nws, nsdata;
    logic              nboundary;
    logic              fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_dout;

    i2s_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sclk    (sclk),
        .rst     (rst),
        .push_i  (frame_valid_i),
        .din_i   (frame_i),
        .pop_i   (nboundary),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign frame_ready_o = !fifo_full;
    assign busy_o        = (state != IDLE);

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            slot_cnt <= '0;
        end else begin
            state    <= nstate;
            bit_cnt  <= nbit;
            slot_cnt <= nslot;
        end
    end

    always_comb begin
        nstate = state;
        nbit   = bit_cnt;
        nslot  = slot_cnt;
        unique case (state)
            IDLE: begin
                if (en_i) begin
                    nstate = RUN;
                    nbit   = '0;
                    nslot  = '0;
                end
            end
            RUN: begin
                if (bit_cnt == BIT_LAST) begin
                    nbit = '0;
                    if (slot_cnt == SLOT_LAST) begin
                        nslot = '0;
                        if (!en_i) nstate = (fmt_q == FMT_I2S) ? DRAIN : IDLE;
                    end else begin
                        nslot = slot_cnt + 1'b1;
                    end
                end else begin
                    nbit = bit_cnt + 1'b1;
                end
            end
            DRAIN:   nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Outputs are registered, so everything below describes the coming
    // cycle: the frame-boundary pop and fmt latch happen on the edge into it.
    always_comb begin
        nboundary = (nstate == RUN) && (nbit == '0) && (nslot == '0);
        nfmt      = nboundary ? decode_fmt(fmt_i) : fmt_q;
        nframe    = frame_q;
        if (nboundary) nframe = fifo_empty ? '0 : fifo_dout;
        smp    = SAMPLE_W'(nframe >> (32'(nslot) * SAMPLE_W));
        nlj    = (nstate == RUN) && |(smp & (SMP_MSB >> nbit));
        // I2S is the left-justified stream one cycle late.
        nsdata = (nstate == IDLE) ? 1'b0 : ((nfmt == FMT_I2S) ? lj_q : nlj);
        unique case (nstate)
            RUN:     nws = (nfmt == FMT_DSP) ? ((nbit == '0) && (nslot == '0))
                                             : (nslot >= SLOT_HALF);
            DRAIN:   nws = 1'b1;
            default: nws = (nfmt != FMT_DSP);
        endcase
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            fmt_q      <= FMT_I2S;
            frame_q    <= '0;
            lj_q       <= 1'b0;
            ws_o       <= 1'b1;
            sdata_o    <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            fmt_q      <= nfmt;
            frame_q    <= nframe;
            lj_q       <= nlj;
            ws_o       <= nws;
            sdata_o    <= nsdata;
            underrun_o <= nboundary && fifo_empty;
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Self-checking bench for i2s_tdm_tx: format table, underrun, back-pressure,
// TDM configuration, reset mid-frame and randomized runs against a model.
module tb_i2s_tdm_tx;

    logic        sclk;
    logic        rst;
    logic        en_a, valid_a, rdy_a, ws_a, sd_a, bz_a, ur_a;
    logic [1:0]  fmt_a;
    logic [31:0] frame_a;
    logic [2:0]  lvl_a;
    logic        en_b, valid_b, rdy_b, ws_b, sd_b, bz_b, ur_b;
    logic [1:0]  fmt_b;
    logic [95:0] frame_b;
    logic [2:0]  lvl_b;

    int checks = 0;
    int errors = 0;

    logic [127:0] mframes [8];
    logic         cap_sd [0:299];

    typedef struct {
        logic [1:0]  fmt;
        logic [15:0] l;
        logic [15:0] r;
        logic        exp_ws0;
        int          exp_busy;
    } vec_t;
    vec_t tbl [4];

    i2s_tdm_tx u_dut_a (
        .sclk          (sclk),
        .rst           (rst),
        .en_i          (en_a),
        .fmt_i         (fmt_a),
        .frame_i       (frame_a),
        .frame_valid_i (valid_a),
        .frame_ready_o (rdy_a),
        .ws_o          (ws_a),
        .sdata_o       (sd_a),
        .busy_o        (bz_a),
        .underrun_o    (ur_a),
        .fifo_level_o  (lvl_a)
    );

    i2s_tdm_tx #(
        .SAMPLE_W (24),
        .SLOT_W   (32),
        .CHANNELS (4),
        .DEPTH    (4)
    ) u_dut_b (
        .sclk          (sclk),
        .rst           (rst),
        .en_i          (en_b),
        .fmt_i         (fmt_b),
        .frame_i       (frame_b),
        .frame_valid_i (valid_b),
        .frame_ready_o (rdy_b),
        .ws_o          (ws_b),
        .sdata_o       (sd_b),
        .busy_o        (bz_b),
        .underrun_o    (ur_b),
        .fifo_level_o  (lvl_b)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Left-justified data bit at cycle i after T0, from the frame list.
    function automatic logic m_lj(input int i, input int nfr, input int ndata,
                                  input int ch, input int slw, input int smw);
        int fp, f, r, s, b;
        logic [127:0] sh;
        fp = ch*slw;
        if (i < 0 || i >= nfr*fp) return 1'b0;
        f = i / fp;
        r = i % fp;
        s = r / slw;
        b = r % slw;
        if (f >= ndata || b >= smw) return 1'b0;
        sh = mframes[f] >> (s*smw);
        return sh[smw-1-b];
    endfunction

    task automatic push(input bit sel, input logic [127:0] fr);
        int n;
        n = 0;
        while (!(sel ? rdy_b : rdy_a) && n < 400) begin
            @(negedge sclk);
            n++;
        end
        chk("push_wait", (n < 400), 1'b1);
        if (sel) begin frame_b = fr[95:0]; valid_b = 1'b1; end
        else     begin frame_a = fr[31:0]; valid_a = 1'b1; end
        @(negedge sclk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic run_check(input bit sel, input logic [1:0] fmt, input int nfr,
                             input int ndata, input string tag,
                             output int bz_cnt, output logic ws0);
        int ch, slw, smw, fp, last, r, s;
        logic i2s, dsp, e_ws, e_sd, e_bz, e_ur, do_ws;
        logic a_ws, a_sd, a_bz, a_ur;
        ch   = sel ? 4 : 2;
        slw  = sel ? 32 : 16;
        smw  = sel ? 24 : 16;
        fp   = ch*slw;
        last = nfr*fp;
        dsp  = (fmt == 2'd2);
        i2s  = (fmt == 2'd0) || (fmt == 2'd3);
        bz_cnt = 0;
        ws0    = 1'b0;
        if (sel) begin fmt_b = fmt; en_b = 1'b1; end
        else     begin fmt_a = fmt; en_a = 1'b1; end
        for (int i = 0; i <= last + 2; i++) begin
            @(negedge sclk);
            a_ws = sel ? ws_b : ws_a;
            a_sd = sel ? sd_b : sd_a;
            a_bz = sel ? bz_b : bz_a;
            a_ur = sel ? ur_b : ur_a;
            if (i == (nfr-1)*fp) begin en_a = 1'b0; en_b = 1'b0; end
            cap_sd[i] = a_sd;
            if (i == 0) ws0 = a_ws;
            if (a_bz) bz_cnt++;
            do_ws = 1'b1;
            if (i < last) begin
                r    = i % fp;
                s    = r / slw;
                e_ws = dsp ? (r == 0) : (s >= ch/2);
                e_sd = i2s ? m_lj(i-1, nfr, ndata, ch, slw, smw) : m_lj(i, nfr, ndata, ch, slw, smw);
                e_bz = 1'b1;
                e_ur = (r == 0) && ((i / fp) >= ndata);
            end else if (i == last) begin
                do_ws = !i2s;
                e_ws  = !dsp;
                e_sd  = i2s ? m_lj(i-1, nfr, ndata, ch, slw, smw) : 1'b0;
                e_bz  = i2s;
                e_ur  = 1'b0;
            end else begin
                e_ws = !dsp;
                e_sd = 1'b0;
                e_bz = 1'b0;
                e_ur = 1'b0;
            end
            if (do_ws) chk($sformatf("%s ws@%0d", tag, i), a_ws, e_ws);
            chk($sformatf("%s sdata@%0d", tag, i), a_sd, e_sd);
            chk($sformatf("%s busy@%0d", tag, i), a_bz, e_bz);
            chk($sformatf("%s underrun@%0d", tag, i), a_ur, e_ur);
        end
    endtask

    initial begin
        int bz;
        logic w0;
        logic [15:0] rx_l, rx_r;
        int nd, nf;
        logic [1:0] f;

        rst = 1'b0;
        en_a = 1'b0; valid_a = 1'b0; fmt_a = 2'd0; frame_a = '0;
        en_b = 1'b0; valid_b = 1'b0; fmt_b = 2'd0; frame_b = '0;
        repeat (3) @(negedge sclk);
        chk("rst ws", ws_a, 1'b1);
        chk("rst sdata", sd_a, 1'b0);
        chk("rst busy", bz_a, 1'b0);
        chk("rst underrun", ur_a, 1'b0);
        chk("rst level", lvl_a, 3'd0);
        chk("rst ready", rdy_a, 1'b1);
        chk("rst b ws", ws_b, 1'b1);
        chk("rst b level", lvl_b, 3'd0);
        rst = 1'b1;
        @(negedge sclk);

        // Format table: I2S, LJ, DSP, reserved; en dropped in the first frame.
        tbl[0] = '{2'd0, 16'hdead, 16'hbeef, 1'b0, 33};
        tbl[1] = '{2'd1, 16'hdead, 16'hbeef, 1'b0, 32};
        tbl[2] = '{2'd2, 16'h1234, 16'h8001, 1'b1, 32};
        tbl[3] = '{2'd3, 16'ha5c3, 16'h0ff0, 1'b0, 33};
        for (int k = 0; k < 4; k++) begin
            mframes[0] = {96'b0, tbl[k].r, tbl[k].l};
            push(1'b0, mframes[0]);
            chk($sformatf("tbl%0d level", k), lvl_a, 3'd1);
            run_check(1'b0, tbl[k].fmt, 1, 1, $sformatf("tbl%0d", k), bz, w0);
            chk($sformatf("tbl%0d busy_len", k), bz, tbl[k].exp_busy);
            chk($sformatf("tbl%0d ws_t0", k), w0, tbl[k].exp_ws0);
            if (tbl[k].fmt == 2'd0) begin
                rx_l = '0;
                rx_r = '0;
                for (int j = 1; j <= 16; j++)  rx_l = {rx_l[14:0], cap_sd[j]};
                for (int j = 17; j <= 32; j++) rx_r = {rx_r[14:0], cap_sd[j]};
                chk("loopback L", rx_l, tbl[k].l);
                chk("loopback R", rx_r, tbl[k].r);
            end
        end

        // Empty FIFO for three frames.
        run_check(1'b0, 2'd0, 3, 0, "underrun", bz, w0);

        // Back-pressure: fifth frame waits until the first pop.
        for (int j = 0; j < 5; j++) mframes[j] = {96'b0, $urandom()};
        for (int j = 0; j < 4; j++) push(1'b0, mframes[j]);
        chk("full level", lvl_a, 3'd4);
        chk("full ready", rdy_a, 1'b0);
        frame_a = mframes[4][31:0];
        valid_a = 1'b1;
        repeat (3) @(negedge sclk);
        chk("held level", lvl_a, 3'd4);
        chk("held ready", rdy_a, 1'b0);
        fork
            run_check(1'b0, 2'd1, 5, 5, "bp", bz, w0);
            begin
                int n;
                n = 0;
                while (!rdy_a && n < 400) begin
                    @(negedge sclk);
                    n++;
                end
                chk("bp ready_wait", (n < 400), 1'b1);
                @(negedge sclk);
                valid_a = 1'b0;
            end
        join
        chk("bp level_end", lvl_a, 3'd0);

        // TDM: 4 x 24-bit samples in 32-bit slots, DSP, then one silent frame.
        mframes[0] = {32'b0, 24'h800000, 24'h7fffff, 24'h123456, 24'habcdef};
        push(1'b1, mframes[0]);
        run_check(1'b1, 2'd2, 2, 1, "tdm", bz, w0);
        chk("tdm busy_len", bz, 256);
        chk("tdm ws_t0", w0, 1'b1);

        // Reset mid-slot discards the FIFO and forces outputs asynchronously.
        mframes[0] = {96'b0, 32'hffff_ffff};
        push(1'b0, mframes[0]);
        push(1'b0, {96'b0, 32'h1357_9bdf});
        fmt_a = 2'd1;
        en_a  = 1'b1;
        repeat (5) @(negedge sclk);
        chk("pre-rst ws", ws_a, 1'b0);
        chk("pre-rst sdata", sd_a, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid-rst ws", ws_a, 1'b1);
        chk("mid-rst sdata", sd_a, 1'b0);
        chk("mid-rst level", lvl_a, 3'd0);
        chk("mid-rst busy", bz_a, 1'b0);
        chk("mid-rst ready", rdy_a, 1'b1);
        en_a = 1'b0;
        @(negedge sclk);
        rst = 1'b1;
        @(negedge sclk);
        mframes[0] = {96'b0, 32'h6b2e_91c4};
        push(1'b0, mframes[0]);
        run_check(1'b0, 2'd0, 2, 1, "post-rst", bz, w0);

        // Randomized runs on both configurations.
        for (int it = 0; it < 6; it++) begin
            f  = 2'($urandom_range(0, 3));
            nd = $urandom_range(0, 4);
            nf = nd + $urandom_range(0, 1);
            if (nf == 0) nf = 1;
            for (int j = 0; j < nd; j++) begin
                mframes[j] = {96'b0, $urandom()};
                push(1'b0, mframes[j]);
            end
            run_check(1'b0, f, nf, nd, $sformatf("rnd%0d", it), bz, w0);
        end
        for (int it = 0; it < 2; it++) begin
            f  = 2'($urandom_range(0, 3));
            nd = $urandom_range(1, 2);
            for (int j = 0; j < nd; j++) begin
                mframes[j] = {32'b0, $urandom(), $urandom(), $urandom()};
                push(1'b1, mframes[j]);
            end
            run_check(1'b1, f, nd, nd, $sformatf("rndb%0d", it), bz, w0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
